// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency word reads and
// buffers returned instructions in a small queue that feeds decode via valid/ready.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  input  logic        id_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // A redirect hides the head in the same cycle so no wrong-path transfer slips through.
  assign if_valid_o = !rst && !redirect_i && (count != '0);
  assign pop        = if_valid_o && id_ready_i;
  assign push       = inflight && !redirect_i && !rst;

  // Credit counts queued plus in-flight words, freeing the slot being popped this cycle.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue  = !rst && !redirect_i && (credit < DEPTH_C);

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc;

  assign if_instr_o = q_instr[head];
  assign if_pc_o    = q_pc[head];
  assign if_pc4_o   = q_pc[head] + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata_i;
        q_pc[tail]    <= inflight_pc;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

endmodule
